// File: rtl/n_way_link_arbiter.sv
// n_way_link_arbiter
//
// Fair, registered arbiter that shares one outgoing link between N requesting
// input links. Round-robin winner selection feeds a one-entry output register,
// giving one packet per cycle sustained throughput. The outgoing request and
// packet come only from registers. The only combinational path runs from
// output_link_ack to input_links_ack.
//
// Optional build macro:
//   TIA_LINK_ARBITER_FIXED_PRIORITY_EN - when defined, the grant pointer is held
//   at 0, so the lowest-index requester always wins. Starvation is possible in
//   this mode. Reset values, latency and handshake rules are the same as in the
//   default round-robin build.
//
// Ports:
//   clock             rising-edge clock for all state
//   reset_n           asynchronous active-low reset
//   input_links_req   [N-1:0]            per-input request
//   input_links_ack   [N-1:0]            per-input ack (at most one high)
//   input_links_tag   [N*TagWidth-1:0]   per-input tag, input k at slice k
//   input_links_data  [N*WordWidth-1:0]  per-input data, input k at slice k
//   output_link_req                      output register holds a packet
//   output_link_ack                      downstream accepts the held packet
//   output_link_tag   [TagWidth-1:0]     held tag (zero when empty)
//   output_link_data  [WordWidth-1:0]    held data (zero when empty)
//   output_source     [PTR_WIDTH-1:0]    index of the input whose packet is held

module n_way_link_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned TagWidth  = 3,
  parameter int unsigned WordWidth = 32,
  localparam int unsigned PTR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N-1:0]           input_links_req,
  output logic [N-1:0]           input_links_ack,
  input  logic [N*TagWidth-1:0]  input_links_tag,
  input  logic [N*WordWidth-1:0] input_links_data,
  output logic                   output_link_req,
  input  logic                   output_link_ack,
  output logic [TagWidth-1:0]    output_link_tag,
  output logic [WordWidth-1:0]   output_link_data,
  output logic [PTR_WIDTH-1:0]   output_source
);

  localparam logic [PTR_WIDTH:0] NVal = (PTR_WIDTH + 1)'(N);

  // Output register and grant pointer.
  logic                 out_valid_q, out_valid_d;
  logic [TagWidth-1:0]  out_tag_q, out_tag_d;
  logic [WordWidth-1:0] out_data_q, out_data_d;
  logic [PTR_WIDTH-1:0] out_src_q, out_src_d;
  logic [PTR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  // Selection signals.
  logic                 any_req;
  logic                 accept_ready;
  logic                 accept;
  logic [2*N-1:0]       req_dbl;
  logic [2*N-1:0]       req_shifted;
  logic [N-1:0]         req_rot;
  logic [PTR_WIDTH:0]   offset;
  logic [PTR_WIDTH:0]   win_sum;
  logic [PTR_WIDTH-1:0] winner;
  logic [PTR_WIDTH:0]   ptr_inc;
  logic [TagWidth-1:0]  win_tag;
  logic [WordWidth-1:0] win_data;
  logic [N-1:0]         win_onehot;
  logic                 found;

  assign any_req      = |input_links_req;
  // Drain-and-refill: a full register can take a new packet on the edge it drains.
  assign accept_ready = !out_valid_q || output_link_ack;
  assign accept       = any_req && accept_ready;

  // Rotate the request vector so that bit 0 corresponds to rr_ptr; the first set
  // bit of the rotated vector is the offset of the winner from the pointer.
  always_comb begin
    req_dbl     = {input_links_req, input_links_req};
    req_shifted = req_dbl >> rr_ptr_q;
    req_rot     = req_shifted[N-1:0];
    offset      = '0;
    found       = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = (PTR_WIDTH + 1)'(k);
      end
    end
  end

  // Map the offset back to an absolute index, wrapping at N.
  always_comb begin
    win_sum = {1'b0, rr_ptr_q} + offset;
    if (win_sum >= NVal) begin
      win_sum = win_sum - NVal;
    end
    winner = win_sum[PTR_WIDTH-1:0];

    ptr_inc = {1'b0, winner} + (PTR_WIDTH + 1)'(1);
    if (ptr_inc >= NVal) begin
      ptr_inc = '0;
    end
  end

  // Winner packet mux and one-hot grant.
  always_comb begin
    win_tag    = '0;
    win_data   = '0;
    win_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (winner == PTR_WIDTH'(k)) begin
        win_onehot[k] = 1'b1;
        win_tag       = input_links_tag[k*TagWidth +: TagWidth];
        win_data      = input_links_data[k*WordWidth +: WordWidth];
      end
    end
  end

  // Acks are gated by reset so nothing is consumed while the block is held in reset.
  assign input_links_ack = (accept && reset_n) ? win_onehot : '0;

  // Next-state for the output register and pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_tag_d   = win_tag;
      out_data_d  = win_data;
      out_src_d   = winner;
`ifdef TIA_LINK_ARBITER_FIXED_PRIORITY_EN
      rr_ptr_d    = '0;
`else
      rr_ptr_d    = ptr_inc[PTR_WIDTH-1:0];
`endif
    end else if (out_valid_q && output_link_ack) begin
      // Plain drain: clear payload so the idle link shows zeros; keep source/pointer.
      out_valid_d = 1'b0;
      out_tag_d   = '0;
      out_data_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign output_link_req  = out_valid_q;
  assign output_link_tag  = out_valid_q ? out_tag_q : '0;
  assign output_link_data = out_valid_q ? out_data_q : '0;
  assign output_source    = out_src_q;

`ifndef SYNTHESIS
  // At most one input is acked in any cycle.
  ack_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(input_links_ack));
  // A stalled output register must not take a new packet.
  stall_no_ack: assert property (@(posedge clock) disable iff (!reset_n)
    (out_valid_q && !output_link_ack) |-> (input_links_ack == '0));
  // The pointer must always name a real input.
  ptr_in_range: assert property (@(posedge clock) disable iff (!reset_n)
    ({1'b0, rr_ptr_q} < NVal));
`endif

endmodule

// File: tb/tb_n_way_link_arbiter.sv
// Self-checking bench for n_way_link_arbiter (N=4). A transaction-level model
// tracks the held packet, its source and the grant pointer; every cycle the DUT
// acks and output link are compared against it. Directed phases pin the model
// with literal expectations, then a randomized phase runs senders that hold
// their request until acked.

module tb_n_way_link_arbiter;

  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 32;
  localparam int PW = 2;

`ifdef TIA_LINK_ARBITER_FIXED_PRIORITY_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    in_req;
  logic [N-1:0]    in_ack;
  logic [N*TW-1:0] in_tag;
  logic [N*DW-1:0] in_data;
  logic            out_req;
  logic            out_ack = 1'b0;
  logic [TW-1:0]   out_tag;
  logic [DW-1:0]   out_data;
  logic [PW-1:0]   out_src;

  always #5 clock = ~clock;

  n_way_link_arbiter #(
    .N         (N),
    .TagWidth  (TW),
    .WordWidth (DW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .input_links_req  (in_req),
    .input_links_ack  (in_ack),
    .input_links_tag  (in_tag),
    .input_links_data (in_data),
    .output_link_req  (out_req),
    .output_link_ack  (out_ack),
    .output_link_tag  (out_tag),
    .output_link_data (out_data),
    .output_source    (out_src)
  );

  // Sender state, one entry per input.
  bit          s_req [N];
  logic [TW-1:0] s_tag [N];
  logic [DW-1:0] s_data [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      in_req[k]            = s_req[k];
      in_tag[k*TW +: TW]   = s_tag[k];
      in_data[k*DW +: DW]  = s_data[k];
    end
  end

  // Model state and its pending next value.
  bit            m_valid, n_valid;
  logic [TW-1:0] m_tag, n_tag;
  logic [DW-1:0] m_data, n_data;
  int            m_src, n_src;
  int            m_ptr, n_ptr;
  int            last_winner;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (s_req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0; m_ptr = 0;
    n_valid = 1'b0; n_tag = '0; n_data = '0; n_src = 0; n_ptr = 0;
    last_winner = -1;
  endtask

  // Compare DUT against the model for the current inputs and compute next state.
  task automatic evaluate_and_check();
    int w;
    bit ready;
    logic [N-1:0] ea;
    w     = model_winner();
    ready = !m_valid || out_ack;
    ea    = '0;
    if (w >= 0 && ready) ea = N'(1) << w;
    chk("ack", 64'(in_ack), 64'(ea));
    chk("out_req", 64'(out_req), 64'(m_valid));
    chk("out_tag", 64'(out_tag), m_valid ? 64'(m_tag) : 64'd0);
    chk("out_data", 64'(out_data), m_valid ? 64'(m_data) : 64'd0);
    chk("out_src", 64'(out_src), 64'(m_src));
    n_valid = m_valid; n_tag = m_tag; n_data = m_data; n_src = m_src; n_ptr = m_ptr;
    last_winner = -1;
    if (w >= 0 && ready) begin
      n_valid = 1'b1;
      n_tag   = s_tag[w];
      n_data  = s_data[w];
      n_src   = w;
      n_ptr   = Fixed ? 0 : (w + 1) % N;
      last_winner = w;
    end else if (m_valid && out_ack) begin
      n_valid = 1'b0;
      n_tag   = '0;
      n_data  = '0;
    end
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    #1;
    evaluate_and_check();
    @(posedge clock);
    m_valid = n_valid; m_tag = n_tag; m_data = n_data; m_src = n_src; m_ptr = n_ptr;
    @(negedge clock);
  endtask

  task automatic clear_senders();
    for (int k = 0; k < N; k++) begin
      s_req[k] = 1'b0; s_tag[k] = '0; s_data[k] = '0;
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [DW-1:0] snap;
  int            exp_grant;

  initial begin
    clear_senders();
    model_reset();
    out_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset state with idle inputs.
    tick();

    // Load a packet and stall it.
    s_req[0] = 1'b1; s_tag[0] = 3'd5; s_data[0] = 32'h1111_1111;
    tick();
    s_req[0] = 1'b0;
    s_req[1] = 1'b1; s_tag[1] = 3'd1; s_data[1] = 32'h2222_2222;
    tick();

    // Asynchronous reset mid-stall, with a request and output ack present.
    out_ack = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_acks", 64'(in_ack), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    s_req[1] = 1'b0;
    s_req[2] = 1'b1; s_tag[2] = 3'd2; s_data[2] = 32'h0000_A5A5;
    #1;
    chk("rst_first_ack", 64'(in_ack), 64'h4);
    tick();
    s_req[2] = 1'b0;

    // Wrap and skip: pointer is 3 in round-robin mode.
    s_req[3] = 1'b1; s_tag[3] = 3'd4; s_data[3] = 32'h3333_0003;
    s_req[0] = 1'b1; s_tag[0] = 3'd6; s_data[0] = 32'h3333_0000;
    #1;
    chk("wrap_first", 64'(in_ack), Fixed ? 64'h1 : 64'h8);
    tick();
    s_req[last_winner] = 1'b0;
    #1;
    chk("wrap_second", 64'(in_ack), Fixed ? 64'h8 : 64'h1);
    tick();
    if (last_winner >= 0) s_req[last_winner] = 1'b0;
    s_req[1] = 1'b1; s_tag[1] = 3'd7; s_data[1] = 32'h4444_0001;
    #1;
    chk("skip_to_1", 64'(in_ack), 64'h2);
    tick();
    s_req[1] = 1'b0;

    // Single requester, latency of one cycle.
    s_req[1] = 1'b1; s_tag[1] = 3'd3; s_data[1] = 32'hDEAD_BEEF;
    #1;
    chk("single_ack", 64'(in_ack), 64'h2);
    tick();
    s_req[1] = 1'b0;
    #1;
    chk("single_out_req", 64'(out_req), 64'd1);
    chk("single_out_tag", 64'(out_tag), 64'd3);
    chk("single_out_data", 64'(out_data), 64'hDEAD_BEEF);
    chk("single_src", 64'(out_src), 64'd1);
    tick();
    // Pointer should now be 2 (round-robin).
    for (int k = 0; k < N; k++) begin
      s_req[k] = 1'b1; s_tag[k] = TW'(k); s_data[k] = 32'h5555_0000 + DW'(k);
    end
    #1;
    chk("ptr_after_single", 64'(in_ack), Fixed ? 64'h1 : 64'h4);
    tick();
    clear_senders();

    // Full contention from a fresh pointer.
    pulse_reset();
    for (int k = 0; k < N; k++) begin
      s_req[k] = 1'b1; s_tag[k] = TW'(k); s_data[k] = 32'hC000_0000 + DW'(k);
    end
    out_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_grant = Fixed ? 0 : c % N;
      #1;
      chk("contend_grant", 64'(in_ack), 64'(1) << exp_grant);
      if (c > 0) chk("contend_no_bubble", 64'(out_req), 64'd1);
      tick();
      if (last_winner >= 0) begin
        s_tag[last_winner]  = TW'(c + 1);
        s_data[last_winner] = 32'hC000_0100 + DW'(c * 16 + last_winner);
      end
    end

    // Backpressure: only inputs 0 and 3 request; output stalled for 5 cycles.
    s_req[1] = 1'b0; s_req[2] = 1'b0;
    s_tag[0] = 3'd1; s_data[0] = 32'hB0B0_0000;
    s_tag[3] = 3'd2; s_data[3] = 32'hB0B0_0003;
    out_ack = 1'b0;
    snap = m_data;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_acks", 64'(in_ack), 64'd0);
      chk("bp_stable", 64'(out_data), 64'(snap));
      tick();
    end
    out_ack = 1'b1;
    #1;
    chk("bp_refill_ack", 64'(in_ack), 64'h1);
    tick();
    s_req[0] = 1'b0;
    #1;
    chk("bp_refill_req", 64'(out_req), 64'd1);
    chk("bp_refill_data", 64'(out_data), 64'hB0B0_0000);
    tick();
    clear_senders();
    tick();

    // Randomized phase.
    for (int c = 0; c < 600; c++) begin
      out_ack = ($urandom_range(9, 0) < 7);
      tick();
      for (int k = 0; k < N; k++) begin
        if (k == last_winner) begin
          if ($urandom_range(1, 0) == 1) begin
            s_tag[k]  = TW'($urandom);
            s_data[k] = $urandom;
          end else begin
            s_req[k] = 1'b0;
          end
        end else if (!s_req[k] && $urandom_range(2, 0) == 0) begin
          s_req[k]  = 1'b1;
          s_tag[k]  = TW'($urandom);
          s_data[k] = $urandom;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/n_way_link_arbiter.md
Name: n_way_link_arbiter

Overview:
- Fair, registered arbiter that shares one outgoing link_if between N incoming link_if requesters. Used where more than one upstream sender can be active at once.
- Round-robin selection, one-entry output register, one packet per cycle sustained throughput.
- Sits between PE/router output ports and a shared channel.

Parameters:
- N, 4, number of input links; legal range N >= 1.
- PTR_WIDTH, max(1, $clog2(N)), width of the grant pointer and source index; derived, not overridden.

Ports:
- clock  input  1  single clock; all state is on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- input_links  link_if.receiver  [N-1:0] of link_if (req, ack, packet.tag TIA_TAG_WIDTH, packet.data TIA_WORD_WIDTH)  requesting senders.
- output_link  link_if.sender  link_if  shared outgoing link.
- output_source  output  PTR_WIDTH  index of the input whose packet is currently held in the output register.

Behaviour:
- Transfer on any link occurs in a cycle where req=1 and ack=1. Senders hold req and packet stable until acked.
- State:
  - out_valid, out_tag, out_data, output_source (registered)
  - rr_ptr (PTR_WIDTH)
- Reset (reset_n=0, asynchronous):
  - out_valid=0, out_tag=0, out_data=0, output_source=0, rr_ptr=0.
  - All input ack forced 0 while reset_n=0.
  - A packet held in the register at reset is discarded.
- Output drive:
  - output_link.req = out_valid.
  - packet = {out_tag, out_data} when out_valid=1, else all zero.
  - No combinational path from any input req/packet to output_link.
- accept_ready = !out_valid || output_link.ack (pipelined drain-and-refill).
- Winner selection: scan indices rr_ptr, rr_ptr+1, ..., wrapping N-1 -> 0. The first input with req=1 wins.
- Input ack (combinational):
  - ack[winner] = accept_ready when any req=1.
  - All other acks = 0.
  - At most one input ack high per cycle.
- Clock edge cases:
  - Accept (any req && accept_ready): load the winner packet, out_valid=1, output_source=winner, rr_ptr=(winner+1) mod N. N-1 wraps to 0.
  - Drain without accept (out_valid && output_link.ack && no req): out_valid=0, tag/data registers cleared to 0. output_source and rr_ptr unchanged.
  - Stall (out_valid && !output_link.ack): hold everything. All input acks are 0.
  - Simultaneous drain and accept: the new packet replaces the old one in the same edge, with no bubble.
- output_link.ack while out_valid=0 is ignored.
- Latency: input acked in cycle t -> output_link.req=1 with that packet from cycle t+1.
- Fairness: with all N inputs continuously requesting and output always acking, grants rotate 0,1,...,N-1,0. Each input is granted exactly once per N cycles.
- N=1: rr_ptr is constant 0, and the block degenerates to a registered link stage.
- Combinational path exists only from output_link.ack to input acks.

Optional Feature:
- Macro TIA_LINK_ARBITER_FIXED_PRIORITY_EN.
- Defined:
  - rr_ptr is held at 0, so the lowest-index requesting input always wins.
  - This matches the priority order of the existing combinational combiner.
  - Starvation is possible and is software's responsibility.
- Undefined (default): round-robin as specified above.
- Reset values, latency and handshake rules are identical in both builds.

Test Plan:
- Reset: assert reset_n=0 mid-stall with out_valid=1 -> output req=0, packet=0, all input acks=0, output_source=0. After release, the first request from input 2 is accepted in the first cycle.
- Single requester: N=4, input 1 sends tag=3, data=0xDEADBEEF, output ack held 1 -> input 1 acked in cycle t. Output req=1 with the same packet in t+1. output_source=1, then rr_ptr=2.
- Full contention: all 4 inputs request continuously, output always acks -> grant order 0,1,2,3,0,1,2,3. One packet per cycle, no bubbles.
- Backpressure: output ack=0 for 5 cycles with inputs 0 and 3 requesting -> no input acks, output packet stable for all 5 cycles. On the ack, a drain and refill happen in the same edge.
- Wrap and skip: rr_ptr=3, only inputs 3 and 0 requesting -> grant 3 then 0. With only input 1 requesting afterward, input 1 is granted next.
- Fixed-priority build (TIA_LINK_ARBITER_FIXED_PRIORITY_EN): inputs 0 and 2 both request continuously -> input 0 is granted every cycle and input 2 never is.
